lpf_capture: RTL and testbench

// Sink end of the low-pass filter sample stream. Takes one DW-bit filter output per qualified clock.

---
 rtl/lpf_capture.sv | 90 +++++++++
 tb/tb_lpf_capture.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/lpf_capture.sv
// lpf_capture: skip settling samples, capture N filter samples into RAM, track min/max, read back in order
module lpf_capture #(
    parameter int DW    = 8,
    parameter int DEPTH = 128,
    parameter int AW    = 7,
    parameter int SKIP  = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_dat,
    input  logic          in_en,
    input  logic          start,
    input  logic [AW:0]   num,
    input  logic          rd_en,
    output logic [DW-1:0] rd_dat,
    output logic          rd_vld,
    output logic          rd_last,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   cap_cnt,
    output logic [DW-1:0] min_dat,
    output logic [DW-1:0] max_dat
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SKIP = 2'd1;
    localparam logic [1:0] ST_CAP  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;
    localparam int SW = (SKIP > 0) ? $clog2(SKIP + 1) : 1;

    logic [1:0]    state;
    logic [AW:0]   n_tgt;
    logic [AW-1:0] rd_ptr;
    logic [SW-1:0] skip_cnt;
    logic [DW-1:0] mem [DEPTH];
    logic          idle_or_done;
    logic [AW:0]   num_clamp;

    assign idle_or_done = (state == ST_IDLE) || (state == ST_DONE);
    assign num_clamp    = (num == '0 || num > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num;
    assign busy         = (state == ST_SKIP) || (state == ST_CAP);
    assign done         = (state == ST_DONE);

    // capture RAM write port, never cleared by reset
    always_ff @(posedge clk)
        if (rst && state == ST_CAP && in_en)
            mem[cap_cnt[AW-1:0]] <= in_dat;

    // control FSM, statistics and read-back port
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            n_tgt    <= '0;
            rd_ptr   <= '0;
            skip_cnt <= '0;
            cap_cnt  <= '0;
            rd_dat   <= '0;
            rd_vld   <= 1'b0;
            rd_last  <= 1'b0;
            min_dat  <= '1;
            max_dat  <= '0;
        end else begin
            rd_vld  <= 1'b0;
            rd_last <= 1'b0;
            if (idle_or_done && start) begin
                n_tgt    <= num_clamp;
                cap_cnt  <= '0;
                skip_cnt <= '0;
                rd_ptr   <= '0;
                min_dat  <= '1;
                max_dat  <= '0;
                state    <= (SKIP == 0) ? ST_CAP : ST_SKIP;
            end else if (state == ST_SKIP && in_en) begin
                skip_cnt <= skip_cnt + 1'b1;
                if (skip_cnt == SW'(SKIP - 1))
                    state <= ST_CAP;
            end else if (state == ST_CAP && in_en) begin
                cap_cnt <= cap_cnt + 1'b1;
                min_dat <= (in_dat < min_dat) ? in_dat : min_dat;
                max_dat <= (in_dat > max_dat) ? in_dat : max_dat;
                if (cap_cnt + 1'b1 == n_tgt)
                    state <= ST_DONE;
            end else if (state == ST_DONE && rd_en) begin
                rd_dat  <= mem[rd_ptr];
                rd_vld  <= 1'b1;
                rd_last <= ({1'b0, rd_ptr} == n_tgt - 1'b1);
                rd_ptr  <= ({1'b0, rd_ptr} == n_tgt - 1'b1) ? '0 : rd_ptr + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_lpf_capture.sv
// tb_lpf_capture: directed stimulus with a read-back scoreboard for lpf_capture
module tb_lpf_capture;
    localparam int SKIP = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_dat;
    logic       in_en;
    logic       start;
    logic [7:0] num;
    logic       rd_en;
    logic [7:0] rd_dat;
    logic       rd_vld;
    logic       rd_last;
    logic       busy;
    logic       done;
    logic [7:0] cap_cnt;
    logic [7:0] min_dat;
    logic [7:0] max_dat;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    lpf_capture #(.DW(8), .DEPTH(128), .AW(7), .SKIP(SKIP)) dut (
        .clk(clk), .rst(rst), .in_dat(in_dat), .in_en(in_en), .start(start), .num(num),
        .rd_en(rd_en), .rd_dat(rd_dat), .rd_vld(rd_vld), .rd_last(rd_last), .busy(busy),
        .done(done), .cap_cnt(cap_cnt), .min_dat(min_dat), .max_dat(max_dat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // read-back monitor: every rd_vld must match the oldest expected sample
    always @(negedge clk) begin
        if (rd_vld) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rd_vld act=%0d exp=none", rd_dat);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rd_dat", int'(rd_dat), int'(e.d));
                chk("rd_last", int'(rd_last), int'(e.l));
            end
        end
    end

    // start a capture; qualified sample q carries value base+q; inj>=0 pulses start after inj stored samples
    task automatic run_cap(input int n_eff, input int nv, input bit alt, input int base, input int inj);
        int q = 0;
        int k = 0;
        start = 1'b1;
        num = 8'(nv);
        in_en = 1'b0;
        tick();
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
        while (q < SKIP + n_eff) begin
            in_en = alt ? (k % 2 == 0) : 1'b1;
            start = (inj >= 0 && in_en && q == SKIP + inj);
            num = start ? 8'd2 : num;
            in_dat = in_en ? 8'(base + q) : 8'hEE;
            q += int'(in_en);
            k++;
            tick();
        end
        in_en = 1'b0;
        start = 1'b0;
        chk("done", int'(done), 1);
        chk("busy_end", int'(busy), 0);
        chk("cap_cnt", int'(cap_cnt), n_eff);
        chk("min_dat", int'(min_dat), (base + SKIP) % 256);
        chk("max_dat", int'(max_dat), (base + SKIP + n_eff - 1) % 256);
    endtask

    task automatic read_n(input int cnt, input int n_eff, input int base);
        for (int i = 0; i < cnt; i++) begin
            exp_t e;
            e.d = 8'(base + SKIP + (i % n_eff));
            e.l = ((i % n_eff) == n_eff - 1);
            sb.push_back(e);
            rd_en = 1'b1;
            tick();
        end
        rd_en = 1'b0;
        tick();
        tick();
        chk("sb_drained", sb.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        in_dat = '0;
        in_en = 1'b0;
        start = 1'b0;
        num = '0;
        rd_en = 1'b0;
        tick();
        tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rd_vld", int'(rd_vld), 0);
        chk("rst_cap_cnt", int'(cap_cnt), 0);
        chk("rst_max", int'(max_dat), 0);
        chk("rst_min", int'(min_dat), 255);
        rst = 1'b1;
        tick();

        run_cap(10, 10, 1'b0, 0, -1);
        read_n(10, 10, 0);

        run_cap(4, 4, 1'b1, 50, -1);
        read_n(4, 4, 50);

        run_cap(128, 0, 1'b0, 0, -1);
        read_n(129, 128, 0);

        run_cap(6, 6, 1'b0, 30, 2);
        read_n(3, 6, 30);
        start = 1'b1;
        num = 8'd3;
        rd_en = 1'b1;
        tick();
        start = 1'b0;
        rd_en = 1'b0;
        chk("start_rd_vld", int'(rd_vld), 0);
        chk("start_rd_busy", int'(busy), 1);
        chk("start_rd_done", int'(done), 0);

        rst = 1'b0;
        tick();
        rst = 1'b1;
        start = 1'b1;
        num = 8'd8;
        tick();
        start = 1'b0;
        in_en = 1'b1;
        for (int i = 0; i < SKIP + 5; i++) begin
            in_dat = 8'(200 - i);
            tick();
        end
        in_en = 1'b0;
        chk("mid_cap_cnt", int'(cap_cnt), 5);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_cap_cnt", int'(cap_cnt), 0);
        chk("mid_rst_min", int'(min_dat), 255);
        chk("mid_rst_max", int'(max_dat), 0);
        run_cap(4, 4, 1'b0, 100, -1);
        read_n(4, 4, 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
